// File: rtl/tmds_deserializer.sv
// TMDS channel receiver: shifts in one bit per clk, captures 10-bit words and
// bit-slips the word boundary until repeated control tokens establish lock.
module tmds_deserializer #(
  parameter int LOCK_COUNT   = 4,
  parameter int SEARCH_WORDS = 64,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       locked,
  output logic       slip
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  localparam logic [3:0]  LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [7:0]  SEARCH_N = 8'(SEARCH_WORDS);
  localparam logic [15:0] LOSS_N   = 16'(LOSS_WORDS);

  state_t      state, state_nxt;
  logic [9:0]  sr;
  logic [3:0]  phase;
  logic [3:0]  match_cnt, match_nxt;
  logic [7:0]  miss_cnt, miss_nxt;
  logic [15:0] loss_cnt, loss_nxt;
  logic        slip_nxt;
  logic        capture;
  logic [9:0]  word;
  logic        tok;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    return (&c) ? c : c + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (&c) ? c : c + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  assign capture = (phase == 4'd9);
  assign word    = {din, sr[9:1]};
  assign tok     = is_token(word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_nxt;
  end

  // Alignment decisions are taken only on the capture edge.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    loss_nxt  = loss_cnt;
    slip_nxt  = 1'b0;
    if (capture) begin
      case (state)
        SEARCH: begin
          if (tok) begin
            miss_nxt  = 8'd0;
            match_nxt = 4'd1;
            loss_nxt  = 16'd0;
            state_nxt = (LOCK_N == 4'd1) ? LOCKED : CONFIRM;
          end else begin
            miss_nxt = sat_inc8(miss_cnt);
            if (miss_nxt == SEARCH_N) begin
              slip_nxt = 1'b1;
              miss_nxt = 8'd0;
            end
          end
        end
        CONFIRM: begin
          if (tok) begin
            match_nxt = sat_inc4(match_cnt);
            if (match_nxt == LOCK_N) begin
              state_nxt = LOCKED;
              loss_nxt  = 16'd0;
            end
          end else begin
            state_nxt = SEARCH;
            miss_nxt  = 8'd1;
            match_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (tok) begin
            loss_nxt = 16'd0;
          end else begin
            loss_nxt = sat_inc16(loss_cnt);
            if (loss_nxt == LOSS_N) begin
              state_nxt = SEARCH;
              match_nxt = 4'd0;
              miss_nxt  = 8'd0;
              loss_nxt  = 16'd0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // A slip wraps phase 9 -> 1 so the next word is one bit short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr         <= 10'd0;
      phase      <= 4'd0;
      dout       <= 10'd0;
      dout_valid <= 1'b0;
      slip       <= 1'b0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 8'd0;
      loss_cnt   <= 16'd0;
    end else begin
      sr        <= word;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      loss_cnt  <= loss_nxt;
      if (capture) begin
        dout       <= word;
        dout_valid <= (state_nxt == LOCKED);
        slip       <= slip_nxt;
        phase      <= slip_nxt ? 4'd1 : 4'd0;
      end else begin
        dout_valid <= 1'b0;
        slip       <= 1'b0;
        phase      <= phase + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tmds_deserializer.sv
// Bench for tmds_deserializer: hand-written vector tables and corner sequences,
// plus a cycle-by-cycle reference model built on an absolute capture schedule.
module tb_tmds_deserializer;

  localparam int LOCK_N   = 4;
  localparam int SEARCH_N = 64;
  localparam int LOSS_N   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [9:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       slip;

  tmds_deserializer #(
    .LOCK_COUNT(LOCK_N),
    .SEARCH_WORDS(SEARCH_N),
    .LOSS_WORDS(LOSS_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dout(dout),
    .dout_valid(dout_valid),
    .locked(locked),
    .slip(slip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bit history, absolute edge of the next capture, alignment state.
  int         m_cyc, m_next_cap, m_state, m_match, m_miss, m_loss;
  bit         m_hist[$];
  logic [9:0] e_dout;
  bit         e_valid, e_slip, e_locked;
  int         slip_cycles[$];

  typedef struct {
    bit         rst_before;
    logic [9:0] word;
    bit         exp_locked;
    bit         exp_valid;
  } vec_t;

  vec_t tbl[12];

  function automatic bit is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cyc = 0; m_next_cap = 10; m_state = 0;
    m_match = 0; m_miss = 0; m_loss = 0;
    m_hist.delete();
    for (int i = 0; i < 10; i++) m_hist.push_back(1'b0);
    e_dout = 10'd0; e_valid = 0; e_slip = 0; e_locked = 0;
  endfunction

  // States: 0 search, 1 confirm, 2 locked.
  function automatic void model_bit(input bit b);
    logic [9:0] w;
    bit t, slipped;
    m_cyc++;
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    e_valid = 0;
    e_slip  = 0;
    if (m_cyc == m_next_cap) begin
      for (int i = 0; i < 10; i++) w[i] = m_hist[i];
      e_dout  = w;
      t       = is_tok(w);
      slipped = 0;
      if (m_state == 0) begin
        if (t) begin
          m_miss = 0; m_match = 1; m_loss = 0;
          m_state = (LOCK_N == 1) ? 2 : 1;
        end else begin
          m_miss++;
          if (m_miss == SEARCH_N) begin slipped = 1; m_miss = 0; end
        end
      end else if (m_state == 1) begin
        if (t) begin
          m_match++;
          if (m_match == LOCK_N) begin m_state = 2; m_loss = 0; end
        end else begin
          m_state = 0; m_miss = 1; m_match = 0;
        end
      end else begin
        if (t) m_loss = 0;
        else begin
          m_loss++;
          if (m_loss == LOSS_N) begin m_state = 0; m_match = 0; m_miss = 0; m_loss = 0; end
        end
      end
      e_valid    = (m_state == 2);
      e_slip     = slipped;
      m_next_cap = m_next_cap + (slipped ? 9 : 10);
    end
    e_locked = (m_state == 2);
  endfunction

  task automatic step(input bit b);
    din = b;
    @(posedge clk);
    #1;
    model_bit(b);
    check("model_outputs", {dout, dout_valid, slip, locked}, {e_dout, e_valid, e_slip, e_locked});
    if (slip) slip_cycles.push_back(m_cyc);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) step(w[i]);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("reset_outputs", {dout, dout_valid, slip, locked}, 32'd0);
    model_reset();
    slip_cycles.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int locked_words;
    bit dropped;
    logic [9:0] rw;

    tbl = '{
      '{1'b1, 10'h354, 1'b0, 1'b0},
      '{1'b0, 10'h354, 1'b0, 1'b0},
      '{1'b0, 10'h354, 1'b0, 1'b0},
      '{1'b0, 10'h354, 1'b1, 1'b1},
      '{1'b0, 10'h354, 1'b1, 1'b1},
      '{1'b1, 10'h2AB, 1'b0, 1'b0},
      '{1'b0, 10'h2AB, 1'b0, 1'b0},
      '{1'b0, 10'h1F0, 1'b0, 1'b0},
      '{1'b0, 10'h0AB, 1'b0, 1'b0},
      '{1'b0, 10'h0AB, 1'b0, 1'b0},
      '{1'b0, 10'h0AB, 1'b0, 1'b0},
      '{1'b0, 10'h0AB, 1'b1, 1'b1}
    };

    #1;
    do_reset();

    // Reset mid-stream, then the first word lands exactly 10 edges after release.
    for (int i = 0; i < 7; i++) step(1'($urandom));
    do_reset();
    rw = 10'h354;
    for (int i = 0; i < 9; i++) step(rw[i]);
    check("first_word_not_yet", dout, 10'h000);
    step(rw[9]);
    check("first_word_dout", dout, 10'h354);
    check("first_word_valid", dout_valid, 1'b0);
    check("first_word_locked", locked, 1'b0);

    // Aligned lock and confirm abort from the vector table.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst_before) do_reset();
      send_word(tbl[i].word);
      check("tbl_dout", dout, tbl[i].word);
      check("tbl_locked", locked, tbl[i].exp_locked);
      check("tbl_valid", dout_valid, tbl[i].exp_valid);
    end
    check("tbl_no_slip", slip_cycles.size(), 0);

    // Loss of lock after LOSS_N misses, with no valid on the losing word.
    for (int i = 0; i < LOSS_N - 1; i++) send_word(10'h1F0);
    check("loss_still_locked", locked, 1'b1);
    send_word(10'h1F0);
    check("loss_dropped", locked, 1'b0);
    check("loss_no_valid", dout_valid, 1'b0);

    // A single token resets the loss counter.
    do_reset();
    for (int i = 0; i < 4; i++) send_word(10'h354);
    dropped = 0;
    for (int i = 0; i < LOSS_N - 1; i++) begin send_word(10'h1F0); if (!locked) dropped = 1; end
    send_word(10'h154);
    if (!locked) dropped = 1;
    for (int i = 0; i < LOSS_N - 1; i++) begin send_word(10'h1F0); if (!locked) dropped = 1; end
    check("loss_cnt_reset_never_dropped", dropped, 1'b0);
    check("loss_cnt_reset_locked", locked, 1'b1);

    // Misaligned by three bits: slips 64 words apart until lock.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0);
    locked_words = 0;
    for (int w = 0; w < 800 && locked_words < 5; w++) begin
      send_word(10'h354);
      if (locked) locked_words++;
    end
    n = slip_cycles.size();
    check("mis_slip_range", (n >= 1 && n <= 9), 1'b1);
    check("mis_locked", locked_words, 5);
    check("mis_dout", dout, 10'h354);
    if (n >= 1) check("mis_first_slip_edge", slip_cycles[0], 640);
    for (int i = 1; i < n; i++) check("mis_slip_spacing", slip_cycles[i] - slip_cycles[i-1], 639);

    // Randomized stream with jitter bits and one mid-stream reset.
    do_reset();
    for (int w = 0; w < 300; w++) begin
      if (w == 150) do_reset();
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) step(1'($urandom));
      end
      case ($urandom_range(0, 9))
        0: rw = 10'h354;
        1: rw = 10'h0AB;
        2: rw = 10'h154;
        3: rw = 10'h2AB;
        4, 5: rw = 10'h1F0;
        default: rw = 10'($urandom);
      endcase
      send_word(rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_deserializer.md
# tmds_deserializer

Serial-to-parallel receiver for one TMDS data channel: the receive-side counterpart of the 10-bit serializer. Samples one bit per `clk`, assembles 10-bit words with the first-received bit in bit 0, and finds word alignment by bit-slipping until TMDS control tokens are seen repeatedly. Aligned 10-bit words go to the TMDS decoder with a valid strobe and a lock indication.

## Interface
- `LOCK_COUNT`, default 4: consecutive control tokens required to declare lock (range 1..15).
- `SEARCH_WORDS`, default 64: words without a control token before one bit slip (range 2..255).
- `LOSS_WORDS`, default 4096: consecutive words without a control token, while locked, before lock is dropped (range 2..65535).

- `clk`  in  1  bit clock, one serial bit per rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data; bit order matches the serializer (word bit 0 first).
- `dout`  out  10  last captured word; bit 0 is the earliest received bit.
- `dout_valid`  out  1  one-cycle pulse: `dout` holds a new aligned word.
- `locked`  out  1  high while the alignment FSM is in LOCKED.
- `slip`  out  1  one-cycle pulse when the word boundary is moved by one bit.

## Operation
- Shift register `sr[9:0]` shifts right every cycle: `sr <= {din, sr[9:1]}`.
- Phase counter `phase`, 0..9, increments every cycle.
- At the edge where `phase == 9`, a capture occurs: `dout <= {din, sr[9:1]}`, i.e. the last 10 bits.
- Normal wrap: phase 9 -> 0.
- Slip: phase 9 -> 1. This shortens the next word by one bit and moves the boundary one bit earlier. Ten slips cover every alignment.
- Control tokens: 10'h354, 10'h0AB, 10'h154, 10'h2AB. Only an exact match counts.
- Three FSM states: SEARCH, CONFIRM, LOCKED. FSM and counters update only at capture edges.
- SEARCH:
  - token -> CONFIRM with `match_cnt = 1`; if `LOCK_COUNT == 1`, go directly to LOCKED.
  - non-token -> `miss_cnt++`. On the capture where `miss_cnt` reaches `SEARCH_WORDS`: pulse `slip`, apply the 9 -> 1 wrap, clear `miss_cnt`.
- CONFIRM:
  - token -> `match_cnt++`; when it reaches `LOCK_COUNT`, go to LOCKED and clear `loss_cnt`.
  - non-token -> SEARCH with `miss_cnt = 1` and `match_cnt = 0`; no slip.
- LOCKED:
  - token -> clear `loss_cnt`.
  - non-token -> `loss_cnt++`. On reaching `LOSS_WORDS`: go to SEARCH, clear all counters, no slip.
- `dout_valid` pulses on a capture edge iff the next state is LOCKED. This includes the word that completes lock and excludes the word that causes loss.
- `dout` updates on every capture regardless of state; it is qualified by `dout_valid`.
- Counters saturate and never wrap. Widths: `match_cnt` 4 bits, `miss_cnt` 8 bits, `loss_cnt` 16 bits.

## Timing
- Reset (`rst` low, asynchronous) forces: `sr = 0`, `phase = 0`, `dout = 10'h000`, `dout_valid = 0`, `locked = 0`, `slip = 0`, state SEARCH, all counters 0.
- Reset release: the first `din` sampled on the first rising edge after `rst` goes high lands in `dout[0]` of the first word.
- Latency: the word's first bit is sampled at edge k. `dout` and `dout_valid` update at edge k+9 and are valid in the following cycle.
- `dout_valid` and `slip` are never high for more than one consecutive cycle. They can only change at capture edges.
- Captures are 10 cycles apart, or 9 cycles apart immediately after a slip.
- `locked` changes at the same edge as the FSM state and stays consistent with it.
- Reset mid-word or mid-confirm discards the partial word and all alignment history. No output pulse is generated at reset assertion.

## Test plan
- Reset: assert `rst` low mid-stream between edges -> all outputs 0 immediately. After release, the first word appears exactly 10 edges later (`dout_valid` still low, state SEARCH).
- Aligned lock: continuous 10'h354 stream, LSB first, starting at reset release -> `locked` rises at the 4th capture edge. `dout_valid` pulses every 10 cycles with `dout == 10'h354`. No `slip` pulses.
- Misaligned lock: same stream delayed by 3 bits -> 1..9 `slip` pulses, each 64 words apart. Then `locked == 1` with `dout == 10'h354`.
- Confirm abort: aligned stream of 2 x 10'h2AB, 1 x 10'h1F0, then 4 x 10'h0AB -> return to SEARCH with no slip, `locked` rises on the 4th 10'h0AB capture.
- Loss of lock: lock, then send 4095 x 10'h1F0 -> still locked. The 4096th 10'h1F0 drops `locked` with no `dout_valid` for that word.
- Loss counter reset: lock, then 4095 x 10'h1F0, one 10'h154, then 4095 x 10'h1F0 -> `locked` stays high throughout.
